hovalaag_io_port: RTL
=====================

# hovalaag_io_port

Host-side I/O responder for the Hovalaag CPU. It feeds the CPU input channels IN1/IN2 from two host-loaded input FIFOs and pops them on IN1_adv/IN2_adv. It captures every OUT word flagged by OUT_valid into one of two output FIFOs chosen by OUT_select, and the host drains them. It sits between the CPU core and the test or host logic, and is the far end of the CPU's IN/OUT protocol.

## Interface
Parameters:
- DEPTH_LOG2, 4: log2 of each FIFO's depth (four FIFOs, each 2^DEPTH_LOG2 × 12 bits).

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_wr_data  in  12  host word to enqueue
- in_wr_sel  in  1  0 = IN1 FIFO, 1 = IN2 FIFO
- in_wr_valid  in  1  enqueue request
- in_wr_ready  out  1  selected input FIFO not full
- IN1  out  12  head of IN1 FIFO; 12'h000 when empty
- IN1_adv  in  1  CPU consumed IN1 word
- IN2  out  12  head of IN2 FIFO; 12'h000 when empty
- IN2_adv  in  1  CPU consumed IN2 word
- OUT  in  12  CPU output word
- OUT_valid  in  1  OUT is a real output this cycle
- OUT_select  in  1  0 = OUT1, 1 = OUT2
- out_rd_sel  in  1  0 = OUT1 FIFO, 1 = OUT2 FIFO
- out_rd_ready  in  1  host dequeue request
- out_rd_valid  out  1  selected output FIFO not empty
- out_rd_data  out  12  head of selected output FIFO; 12'h000 when empty
- underflow  out  2  sticky; bit0 = IN1 popped while empty, bit1 = IN2
- overflow  out  2  sticky; bit0 = OUT1 word dropped while full, bit1 = OUT2
- err_clr  in  1  clears underflow and overflow

## Operation
- Four independent circular FIFOs:
  - Storage is registers.
  - Read and write pointers are DEPTH_LOG2+1 bits wide, with the wrap bit used for full/empty.
  - Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Input enqueue:
  - Occurs on in_wr_valid & in_wr_ready.
  - in_wr_ready is 0 when the selected FIFO is full, so an attempt to write a full FIFO is ignored. It is not an error.
- Input dequeue:
  - INn_adv pops FIFO n.
  - If FIFO n is empty, the pointers do not move and underflow[n-1] is set. The CPU has already consumed 12'h000.
  - IN1_adv and IN2_adv are never both high from a correct CPU. If both are high, each is processed independently.
- Input push and pop in the same cycle on the same FIFO:
  - Both take effect and the count is unchanged.
  - If the FIFO is empty, the push succeeds and the pop counts as an underflow, with no pointer advance.
  - If the FIFO is full, ready is 0, so the pop alone takes effect.
- Output capture:
  - On OUT_valid, OUT is written to the FIFO chosen by OUT_select.
  - If that FIFO is full, the word is dropped and overflow[OUT_select] is set.
- Output capture and host dequeue on the same FIFO in the same cycle:
  - Both take effect.
  - If the FIFO is full, the dequeue frees a slot, so the capture succeeds and no overflow is flagged.
- Output dequeue: occurs on out_rd_ready & out_rd_valid. A request against an empty FIFO is ignored.
- err_clr:
  - Clears both sticky vectors.
  - A new error in the same cycle wins, so its bit stays set.
- Reset values:
  - All pointers are 0 and all FIFOs are empty.
  - IN1 = IN2 = out_rd_data = 12'h000.
  - in_wr_ready = 1, out_rd_valid = 0, underflow = overflow = 2'b00.
- Reset mid-operation discards all queued data immediately (asynchronously).

## Timing
- IN1/IN2, in_wr_ready, out_rd_valid and out_rd_data are combinational from registered FIFO state. They have no dependency on same-cycle inputs except in_wr_sel and out_rd_sel.
- A word pushed at edge k appears on INn after edge k if it lands at the head.
- A pop at edge k presents the next word after edge k. The CPU can consume one word per cycle back-to-back.
- OUT and OUT_valid are registered in the CPU and arrive aligned. Capture happens at the same edge, and out_rd_valid rises after that edge (1-cycle latency).
- Sticky flags update at the edge of the offending event.

## Configuration
- HOVALAAG_IO_LEVEL_EN defined:
  - Adds four outputs, in1_level, in2_level, out1_level and out2_level, each DEPTH_LOG2+1 bits wide.
  - Each holds the registered occupancy count of its FIFO, 0 at reset.
- HOVALAAG_IO_LEVEL_EN undefined: the level ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then push 12'h123 and 12'h456 to IN1 → IN1 = 12'h123. After IN1_adv for one cycle, IN1 = 12'h456; after a second IN1_adv, IN1 = 12'h000 and underflow = 2'b00.
- IN2_adv on an empty IN2 → underflow = 2'b10 and stays set. err_clr for one cycle → 2'b00.
- With DEPTH_LOG2 = 2, push 4 words to IN1 → in_wr_ready = 0 for in_wr_sel = 0 and 1 for in_wr_sel = 1. A fifth push is ignored, and the contents read back in order.
- Drive OUT = 12'hABC with OUT_valid = 1, OUT_select = 1 → next cycle, with out_rd_sel = 1, out_rd_valid = 1 and out_rd_data = 12'hABC; OUT1 FIFO stays empty.
- Fill OUT1 (4 words, DEPTH_LOG2 = 2). A capture alone → dropped, overflow = 2'b01. A capture together with out_rd_ready → accepted, no flag, level remains 4.
- Assert rst asynchronously mid-stream with all FIFOs non-empty → all outputs return to their reset values before the next clock edge.

Source files
------------

// File: rtl/hovalaag_io_port.sv
// hovalaag_io_port: host-side responder for the Hovalaag CPU IN/OUT channels.
// Four register-based circular FIFOs: index 0 = IN1, 1 = IN2, 2 = OUT1, 3 = OUT2.
// Optional feature macro: HOVALAAG_IO_LEVEL_EN adds per-FIFO occupancy outputs.
//
// Handshakes: a host enqueue happens on in_wr_valid & in_wr_ready, and a host
// dequeue happens on out_rd_ready & out_rd_valid. Ready and valid never depend
// on the partner's valid or ready, only on registered FIFO state and the
// channel select. CPU-side pops (INn_adv) and captures (OUT_valid) are
// unconditional strobes: a pop on an empty FIFO or a capture into a full FIFO
// sets a sticky error bit.
module hovalaag_io_port #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] in_wr_data,
  input  logic        in_wr_sel,
  input  logic        in_wr_valid,
  output logic        in_wr_ready,
  output logic [11:0] IN1,
  input  logic        IN1_adv,
  output logic [11:0] IN2,
  input  logic        IN2_adv,
  input  logic [11:0] OUT,
  input  logic        OUT_valid,
  input  logic        OUT_select,
  input  logic        out_rd_sel,
  input  logic        out_rd_ready,
  output logic        out_rd_valid,
  output logic [11:0] out_rd_data,
  output logic [1:0]  underflow,
  output logic [1:0]  overflow,
  input  logic        err_clr
`ifdef HOVALAAG_IO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] in1_level,
  output logic [DEPTH_LOG2:0] in2_level,
  output logic [DEPTH_LOG2:0] out1_level,
  output logic [DEPTH_LOG2:0] out2_level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  // Full is "same slot index, opposite wrap bit".
  localparam logic [PW-1:0] WRAP_BIT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [11:0]   mem [4][DEPTH];
  logic [PW-1:0] wp [4];
  logic [PW-1:0] rp [4];

  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  push;
  logic [3:0]  pop;
  logic [11:0] head  [4];
  logic [11:0] wdata [4];
  logic [1:0]  uf_set;
  logic [1:0]  of_set;

  // Per-FIFO status and head word; an empty FIFO presents zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i] = (wp[i] == rp[i]);
      full[i]  = (wp[i] == (rp[i] ^ WRAP_BIT));
      head[i]  = empty[i] ? 12'h000 : mem[i][rp[i][DEPTH_LOG2-1:0]];
    end
  end

  // Push/pop decisions and error events, all from registered state.
  always_comb begin
    wdata[0] = in_wr_data;
    wdata[1] = in_wr_data;
    wdata[2] = OUT;
    wdata[3] = OUT;

    pop[0]  = IN1_adv & ~empty[0];
    pop[1]  = IN2_adv & ~empty[1];
    pop[2]  = out_rd_ready & ~out_rd_sel & ~empty[2];
    pop[3]  = out_rd_ready &  out_rd_sel & ~empty[3];

    push[0] = in_wr_valid & ~in_wr_sel & ~full[0];
    push[1] = in_wr_valid &  in_wr_sel & ~full[1];
    // A same-cycle host dequeue frees a slot in a full output FIFO.
    push[2] = OUT_valid & ~OUT_select & (~full[2] | pop[2]);
    push[3] = OUT_valid &  OUT_select & (~full[3] | pop[3]);

    uf_set  = {IN2_adv & empty[1], IN1_adv & empty[0]};
    of_set  = {OUT_valid &  OUT_select & full[3] & ~pop[3],
               OUT_valid & ~OUT_select & full[2] & ~pop[2]};
  end

  // Pointer registers; reset empties every FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i])  rp[i] <= rp[i] + 1'b1;
      end
    end
  end

  // Storage writes; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wp[i][DEPTH_LOG2-1:0]] <= wdata[i];
    end
  end

  // Sticky error flags; a new event in the clearing cycle survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 2'b00;
      overflow  <= 2'b00;
    end else begin
      underflow <= (err_clr ? 2'b00 : underflow) | uf_set;
      overflow  <= (err_clr ? 2'b00 : overflow)  | of_set;
    end
  end

  assign IN1          = head[0];
  assign IN2          = head[1];
  assign in_wr_ready  = in_wr_sel ? ~full[1] : ~full[0];
  assign out_rd_valid = out_rd_sel ? ~empty[3] : ~empty[2];
  assign out_rd_data  = out_rd_sel ? head[3] : head[2];

`ifdef HOVALAAG_IO_LEVEL_EN
  // Occupancy is the pointer distance, modulo the pointer range.
  assign in1_level  = wp[0] - rp[0];
  assign in2_level  = wp[1] - rp[1];
  assign out1_level = wp[2] - rp[2];
  assign out2_level = wp[3] - rp[3];
`endif

endmodule
